// File: rtl/jpeg_markers_pkg.sv
// Shared JPEG marker definitions for the header writer and the header parser.
// Holds the marker codes, the header writer FSM state encoding and the
// default maximum Huffman symbol count.
package jpeg_markers_pkg;

  localparam int HUFF_MAX_VALS_DEFAULT = 162;

  localparam logic [7:0] MRK_PREFIX = 8'hFF;
  localparam logic [7:0] MRK_SOI    = 8'hD8;
  localparam logic [7:0] MRK_DQT    = 8'hDB;
  localparam logic [7:0] MRK_SOF0   = 8'hC0;
  localparam logic [7:0] MRK_DHT    = 8'hC4;
  localparam logic [7:0] MRK_SOS    = 8'hDA;
  localparam logic [7:0] MRK_EOI    = 8'hD9;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOI  = 3'd1,
    ST_DQT  = 3'd2,
    ST_SOF  = 3'd3,
    ST_DHT  = 3'd4,
    ST_SOS  = 3'd5,
    ST_DONE = 3'd6
  } jhw_state_e;

endpackage

// File: rtl/jhw_seg_len.sv
// Combinational segment-length calculator for the JPEG header writer.
// Ports:
//   num_components_i  component count (legal: 1 or 3)
//   dht_len_flat_i    16 Huffman code-length counts, count i at [i*8+:8]
//   total_o           sum of the 16 counts (12-bit)
//   lq_o/lf_o/lh_o/ls_o  DQT/SOF0/DHT/SOS length fields
//   reject_o          configuration cannot be emitted
module jhw_seg_len
  import jpeg_markers_pkg::*;
#(
  parameter int HUFF_MAX_VALS = HUFF_MAX_VALS_DEFAULT
) (
  input  logic [3:0]   num_components_i,
  input  logic [127:0] dht_len_flat_i,
  output logic [11:0]  total_o,
  output logic [15:0]  lq_o,
  output logic [15:0]  lf_o,
  output logic [15:0]  lh_o,
  output logic [15:0]  ls_o,
  output logic         reject_o
);

  logic        nc_ok;
  logic [15:0] nc16;
  logic [15:0] nt16;

  always_comb begin
    total_o = '0;
    for (int i = 0; i < 16; i++) begin
      total_o = total_o + {4'b0, dht_len_flat_i[i*8 +: 8]};
    end
  end

  assign nc_ok = (num_components_i == 4'd1) || (num_components_i == 4'd3);
  assign nc16  = {12'b0, num_components_i};
  // One quantisation table for greyscale, two (luma + chroma) for colour.
  assign nt16  = (num_components_i == 4'd3) ? 16'd2 : 16'd1;

  assign lq_o = 16'd2 + 16'd65 * nt16;
  assign lf_o = 16'd8 + 16'd3 * nc16;
  assign lh_o = 16'd19 + {4'b0, total_o};
  assign ls_o = 16'd6 + 16'd2 * nc16;

  assign reject_o = !nc_ok || ({20'b0, total_o} > 32'(HUFF_MAX_VALS));

endmodule

// File: rtl/jpeg_header_writer.sv
// Baseline JPEG header serialiser: on start, emits SOI, DQT, SOF0, DHT, SOS
// as a byte stream with a valid/ready handshake, then pulses done.
// Ports:
//   clk, rst_n (async, active-low), start
//   img_height/img_width/num_components/y_samp  frame description
//   qt0_flat/qt1_flat      quantisation tables, entry k at [k*8+:8]
//   dht_tc_th/dht_len_flat/dht_val_flat  Huffman table
//   byte_out/byte_valid/byte_ready       output stream handshake
//   busy, done, error                     status
module jpeg_header_writer
  import jpeg_markers_pkg::*;
#(
  parameter int HUFF_MAX_VALS = HUFF_MAX_VALS_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [15:0]                img_height,
  input  logic [15:0]                img_width,
  input  logic [3:0]                 num_components,
  input  logic [7:0]                 y_samp,
  input  logic [511:0]               qt0_flat,
  input  logic [511:0]               qt1_flat,
  input  logic [7:0]                 dht_tc_th,
  input  logic [127:0]               dht_len_flat,
  input  logic [HUFF_MAX_VALS*8-1:0] dht_val_flat,
  output logic [7:0]                 byte_out,
  output logic                       byte_valid,
  input  logic                       byte_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  jhw_state_e state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic       err_q, err_d;

  logic [11:0] total_w;
  logic [15:0] lq_w, lf_w, lh_w, ls_w;
  logic        reject_w;

  // Configuration captured at start acceptance (data only, no reset).
  logic [15:0]                h_q, w_q;
  logic [3:0]                 nc_q;
  logic [7:0]                 ysamp_q, tcth_q;
  logic [511:0]               qt0_q, qt1_q;
  logic [127:0]               len_q;
  logic [HUFF_MAX_VALS*8-1:0] val_q;
  logic [11:0]                total_q;
  logic [15:0]                lq_q, lf_q, lh_q, ls_q;

  logic        cfg_load, fire, seg_end;
  logic [15:0] seg_last;
  logic [7:0]  dqt_p, dqt_q, dqt_k, sof_p, sos_p, sos_tail, tail_p, cnt_i, sym_j;
  logic        dqt_hi;

  jhw_seg_len #(.HUFF_MAX_VALS(HUFF_MAX_VALS)) u_seg_len (
    .num_components_i (num_components),
    .dht_len_flat_i   (dht_len_flat),
    .total_o          (total_w),
    .lq_o             (lq_w),
    .lf_o             (lf_w),
    .lh_o             (lh_w),
    .ls_o             (ls_w),
    .reject_o         (reject_w)
  );

  assign cfg_load = (state_q == ST_IDLE) && start && !reject_w;
  assign fire     = byte_valid && byte_ready;

  always_ff @(posedge clk) begin
    if (cfg_load) begin
      h_q     <= img_height;
      w_q     <= img_width;
      nc_q    <= num_components;
      ysamp_q <= y_samp;
      tcth_q  <= dht_tc_th;
      qt0_q   <= qt0_flat;
      qt1_q   <= qt1_flat;
      len_q   <= dht_len_flat;
      val_q   <= dht_val_flat;
      total_q <= total_w;
      lq_q    <= lq_w;
      lf_q    <= lf_w;
      lh_q    <= lh_w;
      ls_q    <= ls_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Each segment ends at index length+1 (marker pair plus length-counted body).
  // The DHT end is taken from the latched symbol total directly.
  always_comb begin
    seg_last = '0;
    case (state_q)
      ST_SOI:  seg_last = 16'd1;
      ST_DQT:  seg_last = lq_q + 16'd1;
      ST_SOF:  seg_last = lf_q + 16'd1;
      ST_DHT:  seg_last = 16'd20 + {4'b0, total_q};
      ST_SOS:  seg_last = ls_q + 16'd1;
      default: seg_last = '0;
    endcase
  end

  assign seg_end = ({8'b0, idx_q} == seg_last);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (reject_w) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_SOI;
            idx_d   = '0;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        if (fire) begin
          if (seg_end) begin
            idx_d = '0;
            case (state_q)
              ST_SOI:  state_d = ST_DQT;
              ST_DQT:  state_d = ST_SOF;
              ST_SOF:  state_d = ST_DHT;
              ST_DHT:  state_d = ST_SOS;
              default: state_d = ST_DONE;
            endcase
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
    endcase
  end

  // Position decoding inside the variable-length parts of each segment.
  assign dqt_p    = idx_q - 8'd4;
  assign dqt_hi   = (dqt_p >= 8'd65);
  assign dqt_q    = dqt_hi ? (dqt_p - 8'd65) : dqt_p;
  assign dqt_k    = dqt_q - 8'd1;
  assign sof_p    = idx_q - 8'd10;
  assign cnt_i    = idx_q - 8'd5;
  assign sym_j    = idx_q - 8'd21;
  assign sos_p    = idx_q - 8'd5;
  assign sos_tail = {3'b0, nc_q, 1'b0} + 8'd5;
  assign tail_p   = idx_q - sos_tail;

  always_comb begin
    byte_out   = 8'h00;
    byte_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_SOI: begin
        byte_valid = 1'b1;
        busy       = 1'b1;
        byte_out   = (idx_q == 8'd0) ? MRK_PREFIX : MRK_SOI;
      end
      ST_DQT: begin
        byte_valid = 1'b1;
        busy       = 1'b1;
        case (idx_q)
          8'd0: byte_out = MRK_PREFIX;
          8'd1: byte_out = MRK_DQT;
          8'd2: byte_out = lq_q[15:8];
          8'd3: byte_out = lq_q[7:0];
          default: begin
            // Each table is its Pq/Tq byte followed by 64 entries.
            if (dqt_q == 8'd0) byte_out = {7'b0, dqt_hi};
            else if (dqt_hi)   byte_out = qt1_q[int'(dqt_k)*8 +: 8];
            else               byte_out = qt0_q[int'(dqt_k)*8 +: 8];
          end
        endcase
      end
      ST_SOF: begin
        byte_valid = 1'b1;
        busy       = 1'b1;
        case (idx_q)
          8'd0: byte_out = MRK_PREFIX;
          8'd1: byte_out = MRK_SOF0;
          8'd2: byte_out = lf_q[15:8];
          8'd3: byte_out = lf_q[7:0];
          8'd4: byte_out = 8'h08;
          8'd5: byte_out = h_q[15:8];
          8'd6: byte_out = h_q[7:0];
          8'd7: byte_out = w_q[15:8];
          8'd8: byte_out = w_q[7:0];
          8'd9: byte_out = {4'b0, nc_q};
          default: begin
            case (sof_p)
              8'd0:    byte_out = 8'h01;
              8'd1:    byte_out = ysamp_q;
              8'd2:    byte_out = 8'h00;
              8'd3:    byte_out = 8'h02;
              8'd4:    byte_out = 8'h11;
              8'd5:    byte_out = 8'h01;
              8'd6:    byte_out = 8'h03;
              8'd7:    byte_out = 8'h11;
              default: byte_out = 8'h01;
            endcase
          end
        endcase
      end
      ST_DHT: begin
        byte_valid = 1'b1;
        busy       = 1'b1;
        case (idx_q)
          8'd0: byte_out = MRK_PREFIX;
          8'd1: byte_out = MRK_DHT;
          8'd2: byte_out = lh_q[15:8];
          8'd3: byte_out = lh_q[7:0];
          8'd4: byte_out = tcth_q;
          default: begin
            if (idx_q < 8'd21) byte_out = len_q[int'(cnt_i)*8 +: 8];
            else               byte_out = val_q[int'(sym_j)*8 +: 8];
          end
        endcase
      end
      ST_SOS: begin
        byte_valid = 1'b1;
        busy       = 1'b1;
        case (idx_q)
          8'd0: byte_out = MRK_PREFIX;
          8'd1: byte_out = MRK_SOS;
          8'd2: byte_out = ls_q[15:8];
          8'd3: byte_out = ls_q[7:0];
          8'd4: byte_out = {4'b0, nc_q};
          default: begin
            if (idx_q < sos_tail) begin
              case (sos_p)
                8'd0:    byte_out = 8'h01;
                8'd1:    byte_out = 8'h00;
                8'd2:    byte_out = 8'h02;
                8'd3:    byte_out = 8'h11;
                8'd4:    byte_out = 8'h03;
                default: byte_out = 8'h11;
              endcase
            end else begin
              // Spectral selection 0..63, no successive approximation.
              byte_out = (tail_p == 8'd1) ? 8'h3F : 8'h00;
            end
          end
        endcase
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign error = err_q;

endmodule

// File: tb/tb_jpeg_header_writer.sv
`timescale 1ns/1ps
module tb_jpeg_header_writer;
  localparam int HMV = 162;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [15:0]      img_height, img_width;
  logic [3:0]       num_components;
  logic [7:0]       y_samp;
  logic [511:0]     qt0_flat, qt1_flat;
  logic [7:0]       dht_tc_th;
  logic [127:0]     dht_len_flat;
  logic [HMV*8-1:0] dht_val_flat;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             byte_ready = 1'b0;
  logic             busy, done, error;

  jpeg_header_writer #(.HUFF_MAX_VALS(HMV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .img_height     (img_height),
    .img_width      (img_width),
    .num_components (num_components),
    .y_samp         (y_samp),
    .qt0_flat       (qt0_flat),
    .qt1_flat       (qt1_flat),
    .dht_tc_th      (dht_tc_th),
    .dht_len_flat   (dht_len_flat),
    .dht_val_flat   (dht_val_flat),
    .byte_out       (byte_out),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] ref_q[$];
  int  stall_bad, drop_bad, done_at;
  bit  timed_out, done_seen, done_busy, done_valid, done_after;

  // ---------------- reference model ----------------
  task automatic push16(input int v);
    exp_q.push_back(8'((v >> 8) & 255));
    exp_q.push_back(8'(v & 255));
  endtask

  task automatic build_expected();
    int nc, nt, tot;
    exp_q.delete();
    nc  = int'(num_components);
    nt  = (nc == 3) ? 2 : 1;
    tot = 0;
    for (int i = 0; i < 16; i++) tot += int'(dht_len_flat[i*8 +: 8]);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hD8);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hDB); push16(2 + 65*nt);
    for (int t = 0; t < nt; t++) begin
      exp_q.push_back(8'(t));
      for (int k = 0; k < 64; k++)
        exp_q.push_back((t == 0) ? qt0_flat[k*8 +: 8] : qt1_flat[k*8 +: 8]);
    end
    exp_q.push_back(8'hFF); exp_q.push_back(8'hC0); push16(8 + 3*nc);
    exp_q.push_back(8'h08);
    push16(int'(img_height)); push16(int'(img_width));
    exp_q.push_back(8'(nc));
    for (int c = 1; c <= nc; c++) begin
      exp_q.push_back(8'(c));
      exp_q.push_back((c == 1) ? y_samp : 8'h11);
      exp_q.push_back((c == 1) ? 8'h00 : 8'h01);
    end
    exp_q.push_back(8'hFF); exp_q.push_back(8'hC4); push16(19 + tot);
    exp_q.push_back(dht_tc_th);
    for (int i = 0; i < 16; i++) exp_q.push_back(dht_len_flat[i*8 +: 8]);
    for (int j = 0; j < tot; j++) exp_q.push_back(dht_val_flat[j*8 +: 8]);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hDA); push16(6 + 2*nc);
    exp_q.push_back(8'(nc));
    for (int c = 1; c <= nc; c++) begin
      exp_q.push_back(8'(c));
      exp_q.push_back((c == 1) ? 8'h00 : 8'h11);
    end
    exp_q.push_back(8'h00); exp_q.push_back(8'h3F); exp_q.push_back(8'h00);
  endtask

  // ---------------- utilities ----------------
  function automatic logic pick(input int pct);
    return ($urandom_range(99, 0) < pct);
  endfunction

  function automatic int qdiff(input logic [7:0] a[$], input logic [7:0] b[$]);
    int n;
    n = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < a.size() && i < b.size(); i++)
      if (a[i] !== b[i]) n++;
    return n;
  endfunction

  function automatic logic [71:0] pack(input int first, input int n);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < n; i++)
      v = (v << 8) | {64'b0, (first + i < got_q.size()) ? got_q[first + i] : 8'hxx};
    return v;
  endfunction

  task automatic rand_config(input int nc);
    img_height     = 16'($urandom);
    img_width      = 16'($urandom);
    num_components = 4'(nc);
    y_samp         = 8'($urandom);
    dht_tc_th      = 8'($urandom);
    for (int k = 0; k < 64; k++) begin
      qt0_flat[k*8 +: 8] = 8'($urandom);
      qt1_flat[k*8 +: 8] = 8'($urandom);
    end
    for (int i = 0; i < 16; i++) dht_len_flat[i*8 +: 8] = 8'($urandom_range(10, 0));
    for (int j = 0; j < HMV; j++) dht_val_flat[j*8 +: 8] = 8'($urandom);
  endtask

  task automatic set_counts(input int c0, input int rest);
    dht_len_flat[7:0] = 8'(c0);
    for (int i = 1; i < 16; i++) dht_len_flat[i*8 +: 8] = 8'(rest);
  endtask

  // Drives one header request and collects accepted bytes.
  task automatic run_header(input int rdy_pct, input bit disturb);
    logic [7:0] prev_b;
    bit prev_stall, started;
    got_q.delete();
    stall_bad = 0; drop_bad = 0; timed_out = 0; done_seen = 0; done_at = -1;
    prev_stall = 0; started = 0; prev_b = 8'h00;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done_seen; cyc++) begin
      if (done) begin
        done_seen  = 1;
        done_at    = cyc;
        done_busy  = busy;
        done_valid = byte_valid;
      end else begin
        byte_ready = pick(rdy_pct);
        if (byte_valid) started = 1;
        else if (started) drop_bad++;
        if (prev_stall && byte_out !== prev_b) stall_bad++;
        if (byte_valid && byte_ready) got_q.push_back(byte_out);
        prev_stall = byte_valid && !byte_ready;
        prev_b     = byte_out;
        if (disturb) begin
          start = ((cyc % 7) == 3);
          rand_config(int'($urandom_range(15, 0)));
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!done_seen) timed_out = 1;
    @(negedge clk);
    done_after = done;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({byte_out, byte_valid, busy, done, error} !== 12'h000) begin
      bad_cnt++;
      $display("FAIL reset_hold: got %h want 000", {byte_out, byte_valid, busy, done, error});
    end
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (byte_out !== 8'h00) begin bad_cnt++; $display("FAIL reset_byte_out: got %h want 00", byte_out); end
    total_cnt++; if (byte_valid !== 1'b0) begin bad_cnt++; $display("FAIL reset_valid: got %b want 0", byte_valid); end
    total_cnt++; if (busy !== 1'b0) begin bad_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
    total_cnt++; if (done !== 1'b0 || error !== 1'b0) begin bad_cnt++; $display("FAIL reset_done_err: got %b%b want 00", done, error); end
  endtask

  task automatic test_nc1();
    int cnt_init[16] = '{0, 1, 5, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    rand_config(1);
    img_height = 16'd480; img_width = 16'd640; y_samp = 8'h11;
    for (int i = 0; i < 16; i++) dht_len_flat[i*8 +: 8] = 8'(cnt_init[i]);
    build_expected();
    run_header(100, 0);
    total_cnt++; if (timed_out) begin bad_cnt++; $display("FAIL nc1_timeout: got no done want done"); end
    total_cnt++; if (got_q.size() != 127) begin bad_cnt++; $display("FAIL nc1_len: got %0d want 127", got_q.size()); end
    total_cnt++; if (qdiff(got_q, exp_q) != 0) begin bad_cnt++; $display("FAIL nc1_stream: got %0d diffs want 0", qdiff(got_q, exp_q)); end
    total_cnt++; if (pack(0, 7) !== 72'h00FFD8FFDB004300) begin bad_cnt++; $display("FAIL nc1_head: got %h want FFD8FFDB004300", pack(0, 7)); end
    total_cnt++; if (pack(76, 5) !== 72'h01E0028001) begin bad_cnt++; $display("FAIL nc1_sof: got %h want 01E0028001", pack(76, 5)); end
    total_cnt++; if (pack(86, 2) !== 72'h001F) begin bad_cnt++; $display("FAIL nc1_lh: got %h want 001F", pack(86, 2)); end
    total_cnt++; if (pack(124, 3) !== 72'h003F00) begin bad_cnt++; $display("FAIL nc1_tail: got %h want 003F00", pack(124, 3)); end
    total_cnt++; if (done_at != 127) begin bad_cnt++; $display("FAIL nc1_done_cycle: got %0d want 127", done_at); end
    total_cnt++;
    if (done_busy !== 1'b0 || done_valid !== 1'b0 || done_after !== 1'b0) begin
      bad_cnt++;
      $display("FAIL nc1_done_pulse: got busy=%b valid=%b next=%b want 0 0 0", done_busy, done_valid, done_after);
    end
  endtask

  task automatic test_nc3();
    int cnt_init[16] = '{0, 1, 5, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    rand_config(3);
    y_samp = 8'h22;
    for (int i = 0; i < 16; i++) dht_len_flat[i*8 +: 8] = 8'(cnt_init[i]);
    build_expected();
    run_header(100, 0);
    total_cnt++; if (got_q.size() != 202) begin bad_cnt++; $display("FAIL nc3_len: got %0d want 202", got_q.size()); end
    total_cnt++; if (qdiff(got_q, exp_q) != 0) begin bad_cnt++; $display("FAIL nc3_stream: got %0d diffs want 0", qdiff(got_q, exp_q)); end
    total_cnt++; if (pack(4, 2) !== 72'h0084) begin bad_cnt++; $display("FAIL nc3_lq: got %h want 0084", pack(4, 2)); end
    total_cnt++; if (pack(71, 1) !== 72'h01) begin bad_cnt++; $display("FAIL nc3_tq1: got %h want 01", pack(71, 1)); end
    total_cnt++; if (pack(138, 2) !== 72'h0011) begin bad_cnt++; $display("FAIL nc3_lf: got %h want 0011", pack(138, 2)); end
    total_cnt++; if (pack(146, 9) !== 72'h012200021101031101) begin bad_cnt++; $display("FAIL nc3_comp: got %h want 012200021101031101", pack(146, 9)); end
    total_cnt++; if (pack(190, 2) !== 72'h000C) begin bad_cnt++; $display("FAIL nc3_ls: got %h want 000C", pack(190, 2)); end
    total_cnt++; if (done_at != 202) begin bad_cnt++; $display("FAIL nc3_done_cycle: got %0d want 202", done_at); end
  endtask

  task automatic test_throttle();
    for (int it = 0; it < 3; it++) begin
      rand_config((it == 1) ? 1 : 3);
      build_expected();
      run_header(100, 0);
      ref_q = got_q;
      run_header(50, 0);
      total_cnt++; if (timed_out) begin bad_cnt++; $display("FAIL thr_timeout[%0d]: got no done want done", it); end
      total_cnt++; if (stall_bad != 0) begin bad_cnt++; $display("FAIL thr_stable[%0d]: got %0d changes want 0", it, stall_bad); end
      total_cnt++; if (drop_bad != 0) begin bad_cnt++; $display("FAIL thr_valid_drop[%0d]: got %0d want 0", it, drop_bad); end
      total_cnt++; if (qdiff(got_q, ref_q) != 0) begin bad_cnt++; $display("FAIL thr_vs_full[%0d]: got %0d diffs want 0", it, qdiff(got_q, ref_q)); end
      total_cnt++; if (qdiff(got_q, exp_q) != 0) begin bad_cnt++; $display("FAIL thr_vs_model[%0d]: got %0d diffs want 0", it, qdiff(got_q, exp_q)); end
    end
  endtask

  task automatic test_total_bounds();
    rand_config(1);
    set_counts(0, 0);
    build_expected();
    run_header(80, 0);
    total_cnt++; if (got_q.size() != 115 || qdiff(got_q, exp_q) != 0) begin bad_cnt++; $display("FAIL total0: got len %0d diffs %0d want 115 0", got_q.size(), qdiff(got_q, exp_q)); end
    rand_config(3);
    set_counts(12, 10);
    build_expected();
    run_header(80, 0);
    total_cnt++; if (got_q.size() != 352 || qdiff(got_q, exp_q) != 0) begin bad_cnt++; $display("FAIL total162: got len %0d diffs %0d want 352 0", got_q.size(), qdiff(got_q, exp_q)); end
  endtask

  task automatic test_reject();
    for (int it = 0; it < 2; it++) begin
      int seen;
      rand_config((it == 0) ? 2 : 3);
      if (it == 1) set_counts(13, 10);
      byte_ready = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total_cnt++; if (error !== 1'b1) begin bad_cnt++; $display("FAIL rej_error[%0d]: got %b want 1", it, error); end
      total_cnt++; if (byte_valid !== 1'b0 || busy !== 1'b0) begin bad_cnt++; $display("FAIL rej_idle[%0d]: got valid=%b busy=%b want 0 0", it, byte_valid, busy); end
      @(negedge clk);
      total_cnt++; if (error !== 1'b0) begin bad_cnt++; $display("FAIL rej_pulse[%0d]: got %b want 0", it, error); end
      seen = 0;
      for (int c = 0; c < 6; c++) begin
        if (byte_valid || busy || done) seen++;
        @(negedge clk);
      end
      total_cnt++; if (seen != 0) begin bad_cnt++; $display("FAIL rej_quiet[%0d]: got %0d active cycles want 0", it, seen); end
    end
  endtask

  task automatic test_busy_disturb();
    rand_config(3);
    build_expected();
    run_header(70, 1);
    total_cnt++; if (timed_out) begin bad_cnt++; $display("FAIL dist_timeout: got no done want done"); end
    total_cnt++; if (qdiff(got_q, exp_q) != 0) begin bad_cnt++; $display("FAIL dist_stream: got %0d diffs want 0", qdiff(got_q, exp_q)); end
    total_cnt++; if (drop_bad != 0) begin bad_cnt++; $display("FAIL dist_valid_drop: got %0d want 0", drop_bad); end
  endtask

  task automatic test_reset_mid();
    int n;
    rand_config(3);
    build_expected();
    byte_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 200 && n < 50; c++) begin
      if (byte_valid && byte_ready) n++;
      if (n < 50) @(negedge clk);
    end
    total_cnt++; if (n != 50) begin bad_cnt++; $display("FAIL rstmid_reach: got %0d bytes want 50", n); end
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({byte_out, byte_valid, busy, done, error} !== 12'h000) begin
      bad_cnt++;
      $display("FAIL rstmid_async: got %h want 000", {byte_out, byte_valid, busy, done, error});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (byte_valid !== 1'b0 || busy !== 1'b0) begin bad_cnt++; $display("FAIL rstmid_idle: got valid=%b busy=%b want 0 0", byte_valid, busy); end
    run_header(100, 0);
    total_cnt++; if (qdiff(got_q, exp_q) != 0) begin bad_cnt++; $display("FAIL rstmid_fresh: got %0d diffs want 0", qdiff(got_q, exp_q)); end
  endtask

  initial begin
    rand_config(1);
    test_reset();
    test_nc1();
    test_nc3();
    test_throttle();
    test_total_bounds();
    test_reject();
    test_busy_disturb();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
